// File: rtl/time_report_tx_if.sv
// TX FIFO side of the time report transmitter: write strobe, byte and the
// FIFO full flag.
interface time_report_tx_if;
   logic       o_tx_push;
   logic [7:0] o_tx_data;
   logic       i_tx_full;

   modport master (
      output o_tx_push,
      output o_tx_data,
      input  i_tx_full
   );

   modport slave (
      input  o_tx_push,
      input  o_tx_data,
      output i_tx_full
   );
endinterface

// File: rtl/time_report_tx.sv
// time_report_tx: on a report tick, snapshots the time fields and pushes the
// ASCII line "HH:MM:SS.CC" [\r] \n into the UART TX FIFO one byte per cycle,
// stalling while the FIFO is full.
// Optional feature: define TIME_REPORT_MODE_PREFIX_EN to prefix the line with
// "W " (watch) or "S " (stopwatch) taken from the snapshot of i_mode.
module time_report_tx #(
   parameter int SEND_CR = 1,
   parameter int HOUR_W  = 5,
   parameter int MIN_W   = 6,
   parameter int CS_W    = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_report_tick,
   input  logic                i_mode,
   input  logic [HOUR_W-1:0]   i_hour,
   input  logic [MIN_W-1:0]    i_min,
   input  logic [MIN_W-1:0]    i_sec,
   input  logic [CS_W-1:0]     i_csec,
   time_report_tx_if.master    tx,
   output logic                o_busy,
   output logic                o_done
);

`ifdef TIME_REPORT_MODE_PREFIX_EN
   localparam int PRE_LEN = 2;
`else
   localparam int PRE_LEN = 0;
`endif
   localparam int         FRAME_LEN = PRE_LEN + 11 + ((SEND_CR != 0) ? 2 : 1);
   localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);
   localparam logic [3:0] PRE_OFS   = 4'(PRE_LEN);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [HOUR_W-1:0] hour_q, hour_d;
   logic [MIN_W-1:0]  min_q, min_d;
   logic [MIN_W-1:0]  sec_q, sec_d;
   logic [CS_W-1:0]   csec_q, csec_d;

`ifdef TIME_REPORT_MODE_PREFIX_EN
   logic mode_q, mode_d;
`else
   logic unused_mode;
   assign unused_mode = i_mode;
`endif

   logic       send_ok;
   logic [3:0] pos;
   logic [6:0] hour_s, min_s, sec_s, csec_s;
   logic [7:0] field_char;
   logic [7:0] frame_char;

   // Fields above 99 are clamped so the two-digit encoding never overflows.
   function automatic logic [6:0] sat99(input logic [15:0] v);
      return (v > 16'd99) ? 7'd99 : v[6:0];
   endfunction

   function automatic logic [7:0] tens_char(input logic [6:0] v);
      logic [6:0] t;
      t = v / 7'd10;
      return 8'h30 + {1'b0, t};
   endfunction

   function automatic logic [7:0] ones_char(input logic [6:0] v);
      logic [6:0] o;
      o = v % 7'd10;
      return 8'h30 + {1'b0, o};
   endfunction

   assign hour_s = sat99(16'(hour_q));
   assign min_s  = sat99(16'(min_q));
   assign sec_s  = sat99(16'(sec_q));
   assign csec_s = sat99(16'(csec_q));

   // A byte leaves whenever a frame is in flight and the FIFO has room.
   assign send_ok = (state_q == SEND) && !tx.i_tx_full;

   // Decode the byte at the current index from the snapshot; the prefix, when
   // present, shifts the time fields by two positions.
   always_comb begin
      pos        = idx_q - PRE_OFS;
      field_char = 8'h00;
      case (pos)
         4'd0:    field_char = tens_char(hour_s);
         4'd1:    field_char = ones_char(hour_s);
         4'd2:    field_char = 8'h3A;
         4'd3:    field_char = tens_char(min_s);
         4'd4:    field_char = ones_char(min_s);
         4'd5:    field_char = 8'h3A;
         4'd6:    field_char = tens_char(sec_s);
         4'd7:    field_char = ones_char(sec_s);
         4'd8:    field_char = 8'h2E;
         4'd9:    field_char = tens_char(csec_s);
         4'd10:   field_char = ones_char(csec_s);
         4'd11:   field_char = (SEND_CR != 0) ? 8'h0D : 8'h0A;
         4'd12:   field_char = 8'h0A;
         default: field_char = 8'h00;
      endcase
      frame_char = field_char;
`ifdef TIME_REPORT_MODE_PREFIX_EN
      if (idx_q == 4'd0) begin
         frame_char = mode_q ? 8'h53 : 8'h57;
      end else if (idx_q == 4'd1) begin
         frame_char = 8'h20;
      end
`endif
   end

   // Next-state logic: capture on a tick in IDLE, advance the index on every
   // accepted byte, and spend one cycle in DONE to raise the completion pulse.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      csec_d  = csec_q;
`ifdef TIME_REPORT_MODE_PREFIX_EN
      mode_d  = mode_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_report_tick) begin
               hour_d  = i_hour;
               min_d   = i_min;
               sec_d   = i_sec;
               csec_d  = i_csec;
`ifdef TIME_REPORT_MODE_PREFIX_EN
               mode_d  = i_mode;
`endif
               idx_d   = 4'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (send_ok) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and snapshot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         csec_q  <= '0;
`ifdef TIME_REPORT_MODE_PREFIX_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         csec_q  <= csec_d;
`ifdef TIME_REPORT_MODE_PREFIX_EN
         mode_q  <= mode_d;
`endif
      end
   end

   // The push is also held off during reset so an aborted frame leaks no byte.
   assign tx.o_tx_push = send_ok && !reset;
   assign tx.o_tx_data = (state_q == SEND) ? frame_char : 8'h00;
   assign o_busy       = (state_q != IDLE);
   assign o_done       = (state_q == DONE);

endmodule
